// File: rtl/bar_update_scheduler_if.sv
// Bar update scheduler bus: vblank, the two command requesters with
// their ready handshake, and the bar renderer / status outputs.
interface bar_update_scheduler_if;
  logic        i_vblank;
  logic        a_valid;
  logic [10:0] a_cmd;
  logic        a_ready;
  logic        b_valid;
  logic [10:0] b_cmd;
  logic        b_ready;
  logic [8:0]  yBar1;
  logic [8:0]  yBar2;
  logic        incDecBar1;
  logic        incDecBar2;
  logic        refreshBar1;
  logic        refreshBar2;
  logic [1:0]  o_pending;
  logic        o_busy;

  // Command sources, vblank timing and the renderer side.
  modport master (
    output i_vblank, a_valid, a_cmd, b_valid, b_cmd,
    input  a_ready, b_ready, yBar1, yBar2, incDecBar1, incDecBar2,
    input  refreshBar1, refreshBar2, o_pending, o_busy
  );

  // The scheduler itself.
  modport slave (
    input  i_vblank, a_valid, a_cmd, b_valid, b_cmd,
    output a_ready, b_ready, yBar1, yBar2, incDecBar1, incDecBar2,
    output refreshBar1, refreshBar2, o_pending, o_busy
  );
endinterface

// File: rtl/bar_update_scheduler.sv
// Bar update scheduler: two 1-entry command holding registers with
// round-robin arbitration; saturating bar moves are committed only during
// vertical blanking, limited to UPD_PER_FRAME commands per blanking interval.
module bar_update_scheduler #(
  parameter logic [8:0] Y_MIN         = 9'd0,
  parameter logic [8:0] Y_MAX         = 9'd420,
  parameter logic [8:0] Y_RESET       = 9'd210,
  parameter logic [2:0] UPD_PER_FRAME = 3'd2
) (
  input logic                   CLK,
  input logic                   RST_BTN,
  bar_update_scheduler_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        vblank_q;
  logic [2:0]  budget_q, budget_d;
  logic        a_full_q, a_full_d, b_full_q, b_full_d;
  logic [10:0] a_cmd_q, a_cmd_d, b_cmd_q, b_cmd_d;
  logic [10:0] work_q, work_d;
  logic        last_b_q, last_b_d;
  logic [8:0]  ybar1_q, ybar1_d, ybar2_q, ybar2_d;
  logic        incdec1_q, incdec1_d, incdec2_q, incdec2_d;
  logic        refresh1_q, refresh1_d, refresh2_q, refresh2_d;
  logic        a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic        busy_q, busy_d;

  logic        a_accept_s, b_accept_s;
  logic        grant_b_s, a_grant_s, b_grant_s;
  logic [8:0]  cur_y_s, new_y_s;

  // Saturating move: 10-bit intermediate so y + mag cannot wrap.
  function automatic logic [8:0] next_pos(input logic [8:0] y,
                                          input logic       inc,
                                          input logic [8:0] mag);
    logic [9:0] sum;
    logic [9:0] room;
    sum  = {1'b0, y} + {1'b0, mag};
    room = {1'b0, y} - {1'b0, Y_MIN};
    if (inc) begin
      if (sum > {1'b0, Y_MAX}) next_pos = Y_MAX;
      else                     next_pos = sum[8:0];
    end else begin
      if ({1'b0, mag} <= room) next_pos = y - mag;
      else                     next_pos = Y_MIN;
    end
  endfunction

  // Ready is registered (never depends on valid), so accept needs only !full.
  assign a_accept_s = bus.a_valid && !a_full_q;
  assign b_accept_s = bus.b_valid && !b_full_q;

  // Round-robin winner: a lone full entry wins, a tie goes to the port not granted last.
  always_comb begin
    if (a_full_q && b_full_q) grant_b_s = !last_b_q;
    else if (b_full_q)        grant_b_s = 1'b1;
    else                      grant_b_s = 1'b0;
  end

  assign a_grant_s = (state_q == S_GRANT) && !grant_b_s;
  assign b_grant_s = (state_q == S_GRANT) && grant_b_s;

  assign cur_y_s = work_q[9] ? ybar2_q : ybar1_q;
  assign new_y_s = next_pos(cur_y_s, work_q[10], work_q[8:0]);

  // Port A holding register: fill on accept, empty when granted.
  always_comb begin
    if (a_accept_s) begin
      a_full_d = 1'b1;
      a_cmd_d  = bus.a_cmd;
    end else if (a_grant_s) begin
      a_full_d = 1'b0;
      a_cmd_d  = a_cmd_q;
    end else begin
      a_full_d = a_full_q;
      a_cmd_d  = a_cmd_q;
    end
  end

  // Port B holding register: fill on accept, empty when granted.
  always_comb begin
    if (b_accept_s) begin
      b_full_d = 1'b1;
      b_cmd_d  = bus.b_cmd;
    end else if (b_grant_s) begin
      b_full_d = 1'b0;
      b_cmd_d  = b_cmd_q;
    end else begin
      b_full_d = b_full_q;
      b_cmd_d  = b_cmd_q;
    end
  end

  // Per-frame budget: reload on vblank rise, zero outside vblank, spend one per apply.
  always_comb begin
    if (!bus.i_vblank)                           budget_d = 3'd0;
    else if (!vblank_q)                          budget_d = UPD_PER_FRAME;
    else if (state_q == S_APPLY && budget_q != 3'd0) budget_d = budget_q - 3'd1;
    else                                         budget_d = budget_q;
  end

  // Sequencer: detect work in IDLE, arbitrate in GRANT, commit the move in APPLY.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    last_b_d   = last_b_q;
    ybar1_d    = ybar1_q;
    ybar2_d    = ybar2_q;
    incdec1_d  = incdec1_q;
    incdec2_d  = incdec2_q;
    refresh1_d = 1'b0;
    refresh2_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_vblank && budget_q != 3'd0 && (a_full_q || b_full_q)) state_d = S_GRANT;
        else                                                            state_d = S_IDLE;
      end
      S_GRANT: begin
        state_d  = S_APPLY;
        last_b_d = grant_b_s;
        if (grant_b_s) work_d = b_cmd_q;
        else           work_d = a_cmd_q;
      end
      S_APPLY: begin
        state_d = S_IDLE;
        if (work_q[9]) begin
          ybar2_d    = new_y_s;
          incdec2_d  = work_q[10];
          refresh2_d = 1'b1;
        end else begin
          ybar1_d    = new_y_s;
          incdec1_d  = work_q[10];
          refresh1_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a_ready_d = !a_full_d;
  assign b_ready_d = !b_full_d;
  assign busy_d    = (state_d != S_IDLE);

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      state_q    <= S_IDLE;
      vblank_q   <= 1'b0;
      budget_q   <= 3'd0;
      a_full_q   <= 1'b0;
      b_full_q   <= 1'b0;
      a_cmd_q    <= 11'd0;
      b_cmd_q    <= 11'd0;
      work_q     <= 11'd0;
      last_b_q   <= 1'b1;
      ybar1_q    <= Y_RESET;
      ybar2_q    <= Y_RESET;
      incdec1_q  <= 1'b0;
      incdec2_q  <= 1'b0;
      refresh1_q <= 1'b0;
      refresh2_q <= 1'b0;
      a_ready_q  <= 1'b1;
      b_ready_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblank_q   <= bus.i_vblank;
      budget_q   <= budget_d;
      a_full_q   <= a_full_d;
      b_full_q   <= b_full_d;
      a_cmd_q    <= a_cmd_d;
      b_cmd_q    <= b_cmd_d;
      work_q     <= work_d;
      last_b_q   <= last_b_d;
      ybar1_q    <= ybar1_d;
      ybar2_q    <= ybar2_d;
      incdec1_q  <= incdec1_d;
      incdec2_q  <= incdec2_d;
      refresh1_q <= refresh1_d;
      refresh2_q <= refresh2_d;
      a_ready_q  <= a_ready_d;
      b_ready_q  <= b_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.a_ready     = a_ready_q;
  assign bus.b_ready     = b_ready_q;
  assign bus.yBar1       = ybar1_q;
  assign bus.yBar2       = ybar2_q;
  assign bus.incDecBar1  = incdec1_q;
  assign bus.incDecBar2  = incdec2_q;
  assign bus.refreshBar1 = refresh1_q;
  assign bus.refreshBar2 = refresh2_q;
  assign bus.o_pending   = {b_full_q, a_full_q};
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_bar_update_scheduler.sv
// Testbench for bar_update_scheduler: a transaction-level model tracks bar
// positions, holding registers, frame budget and the 3-cycle commit slot; a
// per-cycle compare checks every output, and directed scenarios pin literals.
module tb_bar_update_scheduler;
  logic CLK;
  logic RST_BTN;
  bar_update_scheduler_if bus();

  bar_update_scheduler dut (.CLK(CLK), .RST_BTN(RST_BTN), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cnt1 = 0;
  int cnt2 = 0;

  // Model state.
  int          m_y[2];
  bit          m_dir[2];
  bit          m_ref[2];
  bit          m_full[2];
  logic [10:0] m_cmd[2];
  logic [10:0] m_work;
  bit          m_last_b;
  int          m_budget;
  int          m_slot;   // cycles left until the granted command is committed
  bit          m_prev_vb;

  task automatic model_step();
    bit acc[2];
    bit win_b;
    int bar, y, mag, ny;
    if (RST_BTN) begin
      for (int p = 0; p < 2; p++) begin
        m_y[p] <= 210; m_dir[p] <= 1'b0; m_ref[p] <= 1'b0;
        m_full[p] <= 1'b0; m_cmd[p] <= 11'd0;
      end
      m_work <= 11'd0; m_last_b <= 1'b1; m_budget <= 0; m_slot <= 0; m_prev_vb <= 1'b0;
    end else begin
      acc[0] = bus.a_valid && !m_full[0];
      acc[1] = bus.b_valid && !m_full[1];
      win_b  = (m_full[0] && m_full[1]) ? !m_last_b : m_full[1];
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          m_full[p] <= 1'b1;
          m_cmd[p]  <= (p == 0) ? bus.a_cmd : bus.b_cmd;
        end else if (m_slot == 2 && (win_b == (p == 1))) begin
          m_full[p] <= 1'b0;
        end
      end
      if (m_slot == 2) begin
        m_work   <= win_b ? m_cmd[1] : m_cmd[0];
        m_last_b <= win_b;
      end
      m_ref[0] <= 1'b0;
      m_ref[1] <= 1'b0;
      if (m_slot == 1) begin
        bar = int'(m_work[9]);
        y   = m_y[bar];
        mag = int'(m_work[8:0]);
        if (m_work[10]) ny = (y + mag > 420) ? 420 : y + mag;
        else            ny = (mag <= y) ? y - mag : 0;
        m_y[bar]   <= ny;
        m_dir[bar] <= m_work[10];
        m_ref[bar] <= 1'b1;
      end
      if (m_slot > 0) m_slot <= m_slot - 1;
      else if (bus.i_vblank && m_budget > 0 && (m_full[0] || m_full[1])) m_slot <= 2;
      if (!bus.i_vblank)                     m_budget <= 0;
      else if (!m_prev_vb)                   m_budget <= 2;
      else if (m_slot == 1 && m_budget > 0)  m_budget <= m_budget - 1;
      m_prev_vb <= bus.i_vblank;
    end
  endtask

  always @(posedge CLK) model_step();

  // Free-running refresh pulse counters.
  always @(negedge CLK) begin
    if (bus.refreshBar1 === 1'b1) cnt1 <= cnt1 + 1;
    if (bus.refreshBar2 === 1'b1) cnt2 <= cnt2 + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("yBar1",       int'(bus.yBar1),       m_y[0]);
    check("yBar2",       int'(bus.yBar2),       m_y[1]);
    check("incDecBar1",  int'(bus.incDecBar1),  int'(m_dir[0]));
    check("incDecBar2",  int'(bus.incDecBar2),  int'(m_dir[1]));
    check("refreshBar1", int'(bus.refreshBar1), int'(m_ref[0]));
    check("refreshBar2", int'(bus.refreshBar2), int'(m_ref[1]));
    check("a_ready",     int'(bus.a_ready),     int'(!m_full[0]));
    check("b_ready",     int'(bus.b_ready),     int'(!m_full[1]));
    check("o_pending",   int'(bus.o_pending),   int'({m_full[1], m_full[0]}));
    check("o_busy",      int'(bus.o_busy),      int'(m_slot != 0));
  endtask

  task automatic push(input int port, input logic [10:0] cmd);
    int n;
    n = 0;
    if (port == 0) begin bus.a_valid = 1'b1; bus.a_cmd = cmd; end
    else           begin bus.b_valid = 1'b1; bus.b_cmd = cmd; end
    while (((port == 0) ? !bus.a_ready : !bus.b_ready) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL push_timeout port%0d: ready low for %0d cycles", port, n);
    end
    @(negedge CLK);
    if (port == 0) bus.a_valid = 1'b0;
    else           bus.b_valid = 1'b0;
  endtask

  task automatic wait_ref(input int bar, input int lim, output int cyc);
    cyc = 0;
    while (cyc < lim && !((bar == 1) ? bus.refreshBar1 : bus.refreshBar2)) begin
      @(negedge CLK);
      cyc++;
    end
    total++;
    if (cyc >= lim) begin
      bad++;
      $display("FAIL wait_refresh bar%0d: no pulse within %0d cycles", bar, lim);
    end
  endtask

  task automatic do_reset(input int cycles);
    RST_BTN = 1'b1;
    repeat (cycles) @(negedge CLK);
    RST_BTN = 1'b0;
  endtask

  task automatic new_frame();
    bus.i_vblank = 1'b0;
    @(negedge CLK);
    bus.i_vblank = 1'b1;
  endtask

  initial begin
    int cyc, cyc2, c1, c2, n;
    bus.i_vblank = 1'b0;
    bus.a_valid  = 1'b0;
    bus.a_cmd    = 11'd0;
    bus.b_valid  = 1'b0;
    bus.b_cmd    = 11'd0;
    RST_BTN      = 1'b1;
    fork
      forever begin
        @(negedge CLK);
        if (chk_en) compare_all();
      end
    join_none

    // Reset state.
    do_reset(2);
    chk_en = 1'b1;
    check("rst_yBar1", int'(bus.yBar1), 210);
    check("rst_yBar2", int'(bus.yBar2), 210);
    check("rst_ready", int'({bus.a_ready, bus.b_ready}), 3);
    check("rst_refresh", int'({bus.refreshBar1, bus.refreshBar2}), 0);
    check("rst_busy", int'(bus.o_busy), 0);

    // Deferral until vblank.
    push(0, {1'b1, 1'b0, 9'd10});
    c1 = cnt1;
    repeat (5) @(negedge CLK);
    check("defer_no_refresh", cnt1 - c1, 0);
    check("defer_pending", int'(bus.o_pending), 1);
    bus.i_vblank = 1'b1;
    wait_ref(1, 20, cyc);
    check("defer_latency", cyc, 4);
    check("defer_yBar1", int'(bus.yBar1), 220);
    check("defer_incDec1", int'(bus.incDecBar1), 1);
    check("defer_a_ready", int'(bus.a_ready), 1);
    @(negedge CLK);
    check("defer_pulse_width", int'(bus.refreshBar1), 0);
    bus.i_vblank = 1'b0;

    // Round-robin: A wins the first tie, B follows 3 cycles later.
    do_reset(1);
    push(0, {1'b0, 1'b1, 9'd5});
    push(1, {1'b1, 1'b1, 9'd7});
    check("rr_both_pending", int'(bus.o_pending), 3);
    bus.i_vblank = 1'b1;
    wait_ref(2, 20, cyc);
    check("rr_first_A", int'(bus.yBar2), 205);
    check("rr_first_dir", int'(bus.incDecBar2), 0);
    @(negedge CLK);
    wait_ref(2, 20, cyc2);
    check("rr_gap", cyc2 + 1, 3);
    check("rr_second_B", int'(bus.yBar2), 212);
    bus.i_vblank = 1'b0;
    @(negedge CLK);

    // Budget: two commits per frame; the refilled B entry waits for the next frame.
    do_reset(1);
    push(0, {1'b1, 1'b0, 9'd1});
    push(1, {1'b1, 1'b1, 9'd2});
    c1 = cnt1; c2 = cnt2;
    bus.i_vblank = 1'b1;
    push(1, {1'b1, 1'b1, 9'd3});
    repeat (15) @(negedge CLK);
    check("budget_pulses", (cnt1 - c1) + (cnt2 - c2), 2);
    check("budget_leftover", int'(bus.o_pending), 2);
    new_frame();
    wait_ref(2, 20, cyc);
    check("budget_next_frame_B", int'(bus.yBar2), 215);
    check("budget_bar1_quiet", int'(bus.refreshBar1), 0);
    check("budget_yBar1", int'(bus.yBar1), 211);
    bus.i_vblank = 1'b0;
    @(negedge CLK);

    // Saturation at both ends and a zero-magnitude move.
    do_reset(1);
    new_frame();
    push(0, {1'b1, 1'b0, 9'd205});
    wait_ref(1, 20, cyc);
    check("sat_415", int'(bus.yBar1), 415);
    new_frame();
    push(0, {1'b1, 1'b0, 9'd100});
    wait_ref(1, 20, cyc);
    check("sat_max", int'(bus.yBar1), 420);
    new_frame();
    push(0, {1'b0, 1'b0, 9'd511});
    wait_ref(1, 20, cyc);
    check("sat_min", int'(bus.yBar1), 0);
    check("sat_min_dir", int'(bus.incDecBar1), 0);
    new_frame();
    push(1, {1'b0, 1'b1, 9'd0});
    wait_ref(2, 20, cyc);
    check("zero_mag", int'(bus.yBar2), 210);
    bus.i_vblank = 1'b0;
    @(negedge CLK);

    // Reset asserted in the GRANT cycle aborts everything.
    do_reset(1);
    push(0, {1'b1, 1'b0, 9'd50});
    push(1, {1'b1, 1'b1, 9'd30});
    bus.i_vblank = 1'b1;
    n = 0;
    while (!bus.o_busy && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("midop_busy_seen", int'(n < 20), 1);
    RST_BTN = 1'b1;
    @(negedge CLK);
    RST_BTN = 1'b0;
    c1 = cnt1; c2 = cnt2;
    repeat (10) @(negedge CLK);
    check("midop_no_pulse", (cnt1 - c1) + (cnt2 - c2), 0);
    check("midop_yBar1", int'(bus.yBar1), 210);
    check("midop_yBar2", int'(bus.yBar2), 210);
    check("midop_pending", int'(bus.o_pending), 0);
    check("midop_ready", int'({bus.a_ready, bus.b_ready}), 3);
    bus.i_vblank = 1'b0;
    repeat (3) @(negedge CLK);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bar_update_scheduler.md
Name: bar_update_scheduler

Overview:
- Sits between the paddle command sources and the two bar renderers of the Pong display.
- Accepts bar-move commands from two requesters: CPU custom instruction (port A) and the button/AI path (port B). Each requester has a 1-entry holding register; arbitration is round-robin.
- Applies saturating increment/decrement to the tracked bar positions. Position updates are committed only during vertical blanking, with a per-frame command budget, so bars never tear mid-frame.
- Drives yBar/refresh/incDec pulses to the bar renderers.

Parameters:
- Y_MIN, 0, lowest legal bar top coordinate.
- Y_MAX, 420, highest legal bar top coordinate (480 minus bar height).
- Y_RESET, 210, bar position after reset.
- UPD_PER_FRAME, 2, maximum commands applied per vertical blanking interval (1..7).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_BTN  in  1  reset, synchronous, active-high.
- i_vblank  in  1  level; high during vertical blanking, synchronous to CLK.
- a_valid  in  1  port A command valid.
- a_cmd  in  11  port A command: [10] dir (1 inc, 0 dec), [9] bar select (0 bar1, 1 bar2), [8:0] magnitude.
- a_ready  out  1  port A holding register empty.
- b_valid  in  1  port B command valid.
- b_cmd  in  11  port B command, same format as a_cmd.
- b_ready  out  1  port B holding register empty.
- yBar1  out  9  current bar 1 position.
- yBar2  out  9  current bar 2 position.
- incDecBar1  out  1  direction of last bar 1 update.
- incDecBar2  out  1  direction of last bar 2 update.
- refreshBar1  out  1  one-cycle pulse when yBar1 updated.
- refreshBar2  out  1  one-cycle pulse when yBar2 updated.
- o_pending  out  2  {B full, A full}.
- o_busy  out  1  high in GRANT or APPLY.

Behaviour:
- Reset (RST_BTN high at a clock edge):
  - yBar1 = yBar2 = Y_RESET; incDec outputs 0; refresh pulses 0.
  - Both holding registers emptied; any pending command is discarded.
  - Budget = 0; last_grant = B, so A wins the first tie.
  - State = IDLE; any in-flight GRANT/APPLY is aborted.
- Handshake:
  - x_ready = !x_full, registered-state derived, no combinational path from x_valid.
  - Accept when x_valid && x_ready: cmd latched, x_full set next cycle.
  - valid while not ready: command is not taken; the source must hold it.
- Budget:
  - On the rising edge of i_vblank (registered previous value 0, current 1), budget loads UPD_PER_FRAME.
  - When i_vblank is low, budget is forced to 0.
- FSM:
  - IDLE -> GRANT when i_vblank && budget != 0 && (a_full || b_full).
  - GRANT: choose winner.
    - Only one full: that one wins.
    - Both full: the one != last_grant wins.
    - Latch the winner's cmd into the working register; clear the winner's full flag (its ready rises next cycle); update last_grant.
  - GRANT -> APPLY unconditionally.
  - APPLY:
    - Compute the new position of the selected bar with a 10-bit intermediate.
    - inc: min(y + mag, Y_MAX).
    - dec: y - mag if mag <= y - Y_MIN, else Y_MIN.
    - Register the result into yBarN and write incDecBarN.
    - Pulse refreshBarN for exactly this one cycle (other refresh stays 0).
    - Decrement budget.
  - APPLY -> IDLE.
- Latency:
  - Accept to refresh pulse is at least 3 cycles: accept, IDLE detect, GRANT, APPLY.
  - Back-to-back commands issue every 3 cycles.
- Boundary conditions:
  - i_vblank falling during GRANT/APPLY: the committed command still completes; budget is then forced to 0.
  - Accept on a port in the same cycle its entry is granted: impossible, because ready is low while full.
  - Accept during GRANT for the other port: allowed.
  - Magnitude 0: applied normally; refresh still pulses.
  - Magnitude ≥ range: saturates to Y_MIN/Y_MAX.
  - Commands arriving during active video wait in the holding registers; no drop, sources are backpressured.

Test Plan:
- Reset: assert RST_BTN 2 cycles -> yBar1=yBar2=210, a_ready=b_ready=1, refresh=0, o_busy=0.
- Deferral: a_cmd={1,0,9'd10} accepted with i_vblank=0 -> no refresh. Raise i_vblank -> refreshBar1 pulses 1 cycle, yBar1=220, incDecBar1=1, a_ready returns high.
- Round-robin: A={0,1,5} and B={1,1,7} both full before vblank rises -> A applied first (yBar2=205), then B (yBar2=212), 3 cycles apart.
- Budget: UPD_PER_FRAME=2 with A and B refilled continuously -> exactly 2 refresh pulses per vblank. The third command is applied in the next vblank, B-first (alternation continues).
- Saturation:
  - yBar1=415, inc 100 -> 420.
  - Then dec 511 -> 0.
  - Bar2 dec 0 -> unchanged, refreshBar2 still pulses.
- Reset mid-op: RST_BTN asserted in the GRANT cycle -> no refresh pulse follows; positions = 210; both holding registers empty.
